// File: rtl/trng_event_gen.sv
// -----------------------------------------------------------------------------
// trng_event_gen
//
// Collects qualified noise-source bits into an entropy holding register (EHR),
// runs a repetition-count health test and an inactivity watchdog on the bit
// stream, and reports status as single-cycle event pulses for the interrupt
// status stage.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   level, 1 = collection and health tests run
//   rnd_bit_vld  in   qualifies rnd_bit this cycle
//   rnd_bit      in   sampled noise-source bit
//   ehr_read_1p  in   pulse, software has consumed ehr_data
//   rep_thresh   in   [5:0] repetition-count limit, 0 disables the test
//   wdog_limit   in   [15:0] watchdog limit in clk cycles, 0 disables it
//   ehr_data     out  [EHR_W-1:0] collected bits, first bit in bit 0
//   ehr_valid    out  1 while ehr_data holds a complete sample
//   events_1p    out  [VEC_W-1:0] registered one-cycle event pulses:
//                     [0] EHR_VALID, [1] REP_ERR, [2] WDOG, [3] OVERRUN
// -----------------------------------------------------------------------------
module trng_event_gen #(
  parameter int EHR_W = 192,
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rnd_bit_vld,
  input  logic             rnd_bit,
  input  logic             ehr_read_1p,
  input  logic [5:0]       rep_thresh,
  input  logic [15:0]      wdog_limit,
  output logic [EHR_W-1:0] ehr_data,
  output logic             ehr_valid,
  output logic [VEC_W-1:0] events_1p
);

  localparam int         IDX_W    = $clog2(EHR_W);
  localparam logic [7:0] FULL_CNT = 8'(EHR_W);

  localparam int EV_VALID   = 0;
  localparam int EV_REP_ERR = 1;
  localparam int EV_WDOG    = 2;
  localparam int EV_OVERRUN = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [EHR_W-1:0]   ehr_data_q,  ehr_data_d;
  logic               ehr_valid_q, ehr_valid_d;
  logic [7:0]         bit_cnt_q,   bit_cnt_d;
  logic [5:0]         rep_cnt_q,   rep_cnt_d;
  logic               prev_bit_q,  prev_bit_d;
  logic [15:0]        wdog_cnt_q,  wdog_cnt_d;
  logic [VEC_W-1:0]   events_q,    events_d;
  logic [5:0]         rep_next;

  // NOTE: every variable assigned in this block receives a default first, so
  // no path through the case/if structure can leave one unassigned and infer a
  // latch.
  always_comb begin
    state_d     = state_q;
    ehr_data_d  = ehr_data_q;
    ehr_valid_d = ehr_valid_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    prev_bit_d  = prev_bit_q;
    wdog_cnt_d  = wdog_cnt_q;
    events_d    = '0;
    rep_next    = rep_cnt_q;

    if (!enable) begin
      // Dropping enable wins over everything. ehr_data is deliberately kept so
      // software can still read the last sample.
      state_d     = ST_IDLE;
      ehr_valid_d = 1'b0;
      bit_cnt_d   = '0;
      rep_cnt_d   = '0;
      wdog_cnt_d  = '0;
    end else begin
      // ---------------- collection state machine ----------------
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_COLLECT;
        end

        ST_COLLECT: begin
          // ehr_read_1p has no effect here: there is no complete sample yet.
          if (rnd_bit_vld) begin
            ehr_data_d[bit_cnt_q[IDX_W-1:0]] = rnd_bit;
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_d == FULL_CNT) begin
              state_d            = ST_FULL;
              ehr_valid_d        = 1'b1;
              events_d[EV_VALID] = 1'b1;
            end
          end
        end

        ST_FULL: begin
          if (ehr_read_1p) begin
            // The read frees the register in the same cycle, so a coincident
            // bit starts the next sample rather than counting as an overrun.
            state_d     = ST_COLLECT;
            ehr_valid_d = 1'b0;
            bit_cnt_d   = '0;
            if (rnd_bit_vld) begin
              ehr_data_d[0] = rnd_bit;
              bit_cnt_d     = 8'd1;
            end
          end else if (rnd_bit_vld) begin
            events_d[EV_OVERRUN] = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // ---------------- health tests (outside IDLE only) ----------------
      if (state_q != ST_IDLE) begin
        if (rnd_bit_vld) begin
          // rep_cnt_q == 0 marks "no previous bit since leaving IDLE".
          if ((rep_cnt_q == 6'd0) || (rnd_bit != prev_bit_q)) begin
            rep_next = 6'd1;
          end else if (rep_cnt_q == 6'd63) begin
            rep_next = 6'd63;
          end else begin
            rep_next = rep_cnt_q + 6'd1;
          end

          if ((rep_thresh != 6'd0) && (rep_next == rep_thresh)) begin
            events_d[EV_REP_ERR] = 1'b1;
            rep_next             = 6'd1;
          end

          rep_cnt_d  = rep_next;
          prev_bit_d = rnd_bit;
          wdog_cnt_d = '0;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
          if ((wdog_limit != 16'd0) && (wdog_cnt_d == wdog_limit)) begin
            events_d[EV_WDOG] = 1'b1;
            wdog_cnt_d        = '0;
          end
        end
      end
    end
  end

  // NOTE: ehr_data is an ordinary register rather than a RAM, so it takes the
  // asynchronous reset like the rest of the state and reads back as zero after
  // reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ehr_data_q  <= '0;
      ehr_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      prev_bit_q  <= 1'b0;
      wdog_cnt_q  <= '0;
      events_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here make every flop sample the
      // pre-edge value of the *_d signals, independent of statement order.
      state_q     <= state_d;
      ehr_data_q  <= ehr_data_d;
      ehr_valid_q <= ehr_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      prev_bit_q  <= prev_bit_d;
      wdog_cnt_q  <= wdog_cnt_d;
      events_q    <= events_d;
    end
  end

  assign ehr_data  = ehr_data_q;
  assign ehr_valid = ehr_valid_q;
  assign events_1p = events_q;

endmodule

// File: tb/tb_trng_event_gen.sv
// -----------------------------------------------------------------------------
// tb_trng_event_gen
//
// Directed testbench for trng_event_gen (EHR_W = 192). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at that same point, so a
// registered event caused by an input shows up after exactly one tick.
// -----------------------------------------------------------------------------
module tb_trng_event_gen;

  localparam int EHR_W = 192;
  localparam int VEC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             rnd_bit_vld;
  logic             rnd_bit;
  logic             ehr_read_1p;
  logic [5:0]       rep_thresh;
  logic [15:0]      wdog_limit;
  logic [EHR_W-1:0] ehr_data;
  logic             ehr_valid;
  logic [VEC_W-1:0] events_1p;

  int n_cmp = 0;
  int n_bad = 0;

  trng_event_gen #(.EHR_W(EHR_W), .VEC_W(VEC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rnd_bit_vld (rnd_bit_vld),
    .rnd_bit     (rnd_bit),
    .ehr_read_1p (ehr_read_1p),
    .rep_thresh  (rep_thresh),
    .wdog_limit  (wdog_limit),
    .ehr_data    (ehr_data),
    .ehr_valid   (ehr_valid),
    .events_1p   (events_1p)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL timeout: bench did not finish within 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pass through IDLE and come back in COLLECT with all counters cleared.
  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    rnd_bit_vld = 1'b0;
    rnd_bit     = 1'b0;
    ehr_read_1p = 1'b0;
    rep_thresh  = 6'd0;
    wdog_limit  = 16'd0;
    #23;
    n_cmp++;
    if (ehr_data !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", ehr_data);
    end
    n_cmp++;
    if (ehr_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", ehr_valid);
    end
    n_cmp++;
    if (events_1p !== 4'b0000) begin
      n_bad++; $display("FAIL reset_events: got %b want 0000", events_1p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    n_cmp++;
    if (events_1p !== 4'b0000) begin
      n_bad++; $display("FAIL first_enable_events: got %b want 0000", events_1p);
    end
  endtask

  task automatic test_fill();
    logic [EHR_W-1:0] exp_data;
    exp_data = {96{2'b10}};
    for (int i = 0; i < EHR_W; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = i[0];
      tick();
      if (i < EHR_W - 1) begin
        n_cmp++;
        if (events_1p !== 4'b0000) begin
          n_bad++; $display("FAIL fill_events bit %0d: got %b want 0000", i, events_1p);
        end
      end
    end
    rnd_bit_vld = 1'b0;
    n_cmp++;
    if (events_1p !== 4'b0001) begin
      n_bad++; $display("FAIL fill_valid_event: got %b want 0001", events_1p);
    end
    n_cmp++;
    if (ehr_valid !== 1'b1) begin
      n_bad++; $display("FAIL fill_valid: got %b want 1", ehr_valid);
    end
    n_cmp++;
    if (ehr_data !== exp_data) begin
      n_bad++; $display("FAIL fill_data: got %h want %h", ehr_data, exp_data);
    end
    tick();
    n_cmp++;
    if (events_1p !== 4'b0000) begin
      n_bad++; $display("FAIL fill_pulse_width: got %b want 0000", events_1p);
    end
    n_cmp++;
    if (ehr_valid !== 1'b1) begin
      n_bad++; $display("FAIL fill_valid_hold: got %b want 1", ehr_valid);
    end
  endtask

  task automatic test_overrun();
    logic [EHR_W-1:0] exp_data;
    exp_data = {96{2'b10}};
    for (int i = 0; i < 3; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b1;
      tick();
      n_cmp++;
      if (events_1p !== 4'b1000) begin
        n_bad++; $display("FAIL overrun_event %0d: got %b want 1000", i, events_1p);
      end
      n_cmp++;
      if (ehr_data !== exp_data) begin
        n_bad++; $display("FAIL overrun_frozen %0d: got %h want %h", i, ehr_data, exp_data);
      end
    end
    // Read together with a bit: bit becomes bit 0 of the next sample.
    rnd_bit_vld = 1'b1;
    rnd_bit     = 1'b1;
    ehr_read_1p = 1'b1;
    tick();
    ehr_read_1p = 1'b0;
    rnd_bit_vld = 1'b0;
    n_cmp++;
    if (events_1p !== 4'b0000) begin
      n_bad++; $display("FAIL read_vld_events: got %b want 0000", events_1p);
    end
    n_cmp++;
    if (ehr_valid !== 1'b0) begin
      n_bad++; $display("FAIL read_vld_valid: got %b want 0", ehr_valid);
    end
    // 191 more zeros complete the sample; a stray read in COLLECT is ignored.
    for (int i = 1; i < EHR_W; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b0;
      ehr_read_1p = (i == 50);
      tick();
      ehr_read_1p = 1'b0;
      if (i == 100) begin
        n_cmp++;
        if (events_1p !== 4'b0000) begin
          n_bad++; $display("FAIL refill_mid_events: got %b want 0000", events_1p);
        end
      end
    end
    rnd_bit_vld = 1'b0;
    n_cmp++;
    if (events_1p !== 4'b0001) begin
      n_bad++; $display("FAIL refill_event: got %b want 0001", events_1p);
    end
    n_cmp++;
    if (ehr_data !== 192'd1) begin
      n_bad++; $display("FAIL refill_data: got %h want 1", ehr_data);
    end
    ehr_read_1p = 1'b1;
    tick();
    ehr_read_1p = 1'b0;
    n_cmp++;
    if (ehr_valid !== 1'b0) begin
      n_bad++; $display("FAIL plain_read_valid: got %b want 0", ehr_valid);
    end
  endtask

  task automatic test_rep();
    logic [7:0] seq_bits;
    logic [7:0] seq_hits;
    // Eight 1s, threshold 5: one pulse after the 5th bit.
    restart();
    rep_thresh = 6'd5;
    for (int i = 1; i <= 8; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b1;
      tick();
      n_cmp++;
      if (events_1p !== ((i == 5) ? 4'b0010 : 4'b0000)) begin
        n_bad++; $display("FAIL rep5 bit %0d: got %b", i, events_1p);
      end
    end
    rnd_bit_vld = 1'b0;
    // Threshold 0 disables the test.
    restart();
    rep_thresh = 6'd0;
    for (int i = 1; i <= 8; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b1;
      tick();
      n_cmp++;
      if (events_1p !== 4'b0000) begin
        n_bad++; $display("FAIL rep0 bit %0d: got %b want 0000", i, events_1p);
      end
    end
    rnd_bit_vld = 1'b0;
    // Threshold 3, bits 1,1,0,0,0,0,0: counts 1,2,1,2,3*,2,3* (restart at 1).
    restart();
    rep_thresh = 6'd3;
    seq_bits   = 8'b0000_0011;
    seq_hits   = 8'b0101_0000;
    for (int i = 0; i < 7; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = seq_bits[i];
      tick();
      n_cmp++;
      if (events_1p !== {2'b00, seq_hits[i], 1'b0}) begin
        n_bad++; $display("FAIL rep3 bit %0d: got %b want %b", i, events_1p,
                          {2'b00, seq_hits[i], 1'b0});
      end
    end
    rnd_bit_vld = 1'b0;
    rep_thresh  = 6'd0;
  endtask

  task automatic test_wdog();
    wdog_limit = 16'd10;
    // Held in IDLE: no watchdog pulses.
    enable = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_cmp++;
      if (events_1p !== 4'b0000) begin
        n_bad++; $display("FAIL wdog_idle cycle %0d: got %b want 0000", c, events_1p);
      end
    end
    enable = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_cmp++;
      if (events_1p !== (((c % 10) == 0) ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL wdog_free cycle %0d: got %b", c, events_1p);
      end
    end
    // A bit at cycle 7 restarts the count: next pulse at cycle 17.
    for (int c = 1; c <= 20; c++) begin
      rnd_bit_vld = (c == 7);
      rnd_bit     = 1'b0;
      tick();
      n_cmp++;
      if (events_1p !== ((c == 17) ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL wdog_defer cycle %0d: got %b", c, events_1p);
      end
    end
    rnd_bit_vld = 1'b0;
    wdog_limit  = 16'd0;
  endtask

  task automatic test_reset_mid();
    logic [EHR_W-1:0] exp_data;
    restart();
    for (int i = 0; i < 100; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b1;
      tick();
    end
    rnd_bit_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ehr_data !== '0) begin
      n_bad++; $display("FAIL midreset_data: got %h want 0", ehr_data);
    end
    n_cmp++;
    if ((ehr_valid !== 1'b0) || (events_1p !== 4'b0000)) begin
      n_bad++; $display("FAIL midreset_flags: got valid=%b ev=%b want 0/0000",
                        ehr_valid, events_1p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Collect 100 bits, then bounce enable with a bit present while disabled.
    exp_data = '0;
    for (int i = 0; i < 100; i++) begin
      exp_data[i] = ((i % 3) == 0);
      rnd_bit_vld = 1'b1;
      rnd_bit     = ((i % 3) == 0);
      tick();
    end
    enable      = 1'b0;
    rnd_bit_vld = 1'b1;
    rnd_bit     = 1'b1;
    tick();
    rnd_bit_vld = 1'b0;
    n_cmp++;
    if (events_1p !== 4'b0000) begin
      n_bad++; $display("FAIL disable_events: got %b want 0000", events_1p);
    end
    n_cmp++;
    if (ehr_data !== exp_data) begin
      n_bad++; $display("FAIL disable_retain: got %h want %h", ehr_data, exp_data);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (ehr_data !== exp_data) begin
      n_bad++; $display("FAIL reenable_retain: got %h want %h", ehr_data, exp_data);
    end
    // bit_cnt restarted at 0: full only after 192 new bits, not 92.
    for (int i = 1; i <= EHR_W; i++) begin
      rnd_bit_vld = 1'b1;
      rnd_bit     = 1'b0;
      tick();
      if ((i == 92) || (i == EHR_W)) begin
        n_cmp++;
        if (events_1p !== ((i == EHR_W) ? 4'b0001 : 4'b0000)) begin
          n_bad++; $display("FAIL reenable_count bit %0d: got %b", i, events_1p);
        end
      end
    end
    rnd_bit_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overrun();
    test_rep();
    test_wdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
